// File: rtl/div_issue_ctrl_if.sv
// Request/writeback bundle between execute-stage issue logic and div_issue_ctrl.
// Latency: none (wires only).
// Backpressure: req_ready is the only throttle; writeback has no ready.
//
// Ports: req_valid/req_ready/req_op/req_a/req_b/req_tag (issue side),
//        wb_valid/wb_tag/wb_data (writeback side).
interface div_issue_ctrl_if #(
    parameter int TAG_W = 5
);
    logic             req_valid;
    logic             req_ready;
    logic [1:0]       req_op;
    logic [31:0]      req_a;
    logic [31:0]      req_b;
    logic [TAG_W-1:0] req_tag;
    logic             wb_valid;
    logic [TAG_W-1:0] wb_tag;
    logic [31:0]      wb_data;

    // master: the issue stage / writeback consumer
    modport master (
        output req_valid, req_op, req_a, req_b, req_tag,
        input  req_ready, wb_valid, wb_tag, wb_data
    );

    // slave: div_issue_ctrl
    modport slave (
        input  req_valid, req_op, req_a, req_b, req_tag,
        output req_ready, wb_valid, wb_tag, wb_data
    );
endinterface

// File: rtl/div_issue_ctrl.sv
// Divide/remainder front-end: signed->magnitude conversion, corner-case bypass, in-order tagged writeback.
// Latency: LATENCY+1 non-stall edges from accept to wb_valid (core and bypass paths alike).
// Backpressure: none beyond req_ready = rst_n & ~stall; stall freezes every register.
//
// Ports: clk, rst_n (sync, active low), stall, flush, io (div_issue_ctrl_if.slave: req_*, wb_*),
//        div_valid/div_dividend/div_divisor/div_ctrl/div_stall (to core),
//        div_quotient/div_remainder/div_out_valid (from core), inflight, err.
// Optional: define DIV_ALIGN_CHECK_EN to enable the sticky core/tracker alignment check on err.
module div_issue_ctrl #(
    parameter int LATENCY = 28,
    parameter int TAG_W   = 5
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 stall,
    input  logic                 flush,
    div_issue_ctrl_if.slave      io,
    output logic                 div_valid,
    output logic [31:0]          div_dividend,
    output logic [31:0]          div_divisor,
    output logic [1:0]           div_ctrl,
    output logic                 div_stall,
    input  logic [31:0]          div_quotient,
    input  logic [31:0]          div_remainder,
    input  logic                 div_out_valid,
    output logic [5:0]           inflight,
    output logic                 err
);

    typedef struct packed {
        logic             valid;
        logic             ghost;   // flushed op whose core result is still coming
        logic [TAG_W-1:0] tag;
        logic             op1;     // 1 = remainder
        logic             neg;
        logic             byp;
        logic [31:0]      bdata;
    } trk_t;

    trk_t trk [0:LATENCY];
    trk_t head;
    trk_t new_entry;

    logic        accept;
    logic        signed_op;
    logic        by_zero;
    logic        ovf;
    logic        bypass;
    logic [31:0] a_mag;
    logic [31:0] b_mag;
    logic [31:0] byp_data;
    logic [31:0] head_sel;
    logic [31:0] head_res;

    // Flushed entries stop being valid, but those already handed to the core
    // keep a ghost marker so the core's late out_valid still lines up.
    function automatic trk_t kill(input trk_t e);
        trk_t k;
        k       = e;
        k.ghost = e.ghost | (e.valid & ~e.byp);
        k.valid = 1'b0;
        return k;
    endfunction

    assign io.req_ready = rst_n & ~stall;
    assign div_stall    = stall;
    assign accept       = io.req_valid & io.req_ready & ~flush;
    assign signed_op    = ~io.req_op[0];
    assign head         = trk[LATENCY];

    always_comb begin
        a_mag    = (signed_op && io.req_a[31]) ? (~io.req_a + 32'd1) : io.req_a;
        b_mag    = (signed_op && io.req_b[31]) ? (~io.req_b + 32'd1) : io.req_b;
        by_zero  = (io.req_b == 32'd0);
        ovf      = signed_op && (io.req_a == 32'h8000_0000) && (io.req_b == 32'hFFFF_FFFF);
        bypass   = by_zero | ovf;
        // Divide-by-zero wins over overflow (b cannot be both 0 and -1 anyway).
        if (by_zero) byp_data = io.req_op[1] ? io.req_a : 32'hFFFF_FFFF;
        else         byp_data = io.req_op[1] ? 32'd0    : 32'h8000_0000;

        new_entry       = '0;
        new_entry.valid = accept;
        new_entry.tag   = io.req_tag;
        new_entry.op1   = io.req_op[1];
        new_entry.neg   = signed_op & (io.req_op[1] ? io.req_a[31]
                                                    : (io.req_a[31] ^ io.req_b[31]));
        new_entry.byp   = bypass;
        new_entry.bdata = byp_data;
    end

    always_comb begin
        head_sel = head.op1 ? div_remainder : div_quotient;
        head_res = head.byp ? head.bdata : (head.neg ? (~head_sel + 32'd1) : head_sel);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i <= LATENCY; i++) trk[i] <= '0;
            div_valid    <= 1'b0;
            div_dividend <= '0;
            div_divisor  <= '0;
            div_ctrl     <= '0;
            io.wb_valid  <= 1'b0;
            io.wb_tag    <= '0;
            io.wb_data   <= '0;
            inflight     <= '0;
        end else if (flush) begin
            if (!stall) begin
                // Core advances this edge, so the ghosts advance with it.
                trk[0] <= '0;
                for (int i = 1; i <= LATENCY; i++) trk[i] <= kill(trk[i-1]);
                div_valid <= 1'b0;
            end else begin
                for (int i = 0; i <= LATENCY; i++) trk[i] <= kill(trk[i]);
            end
            io.wb_valid <= 1'b0;
            inflight    <= '0;
        end else if (!stall) begin
            trk[0] <= new_entry;
            for (int i = 1; i <= LATENCY; i++) trk[i] <= trk[i-1];
            div_valid <= accept & ~bypass;
            if (accept) begin
                div_dividend <= a_mag;
                div_divisor  <= b_mag;
                div_ctrl     <= io.req_op;
            end
            io.wb_valid <= head.valid;
            if (head.valid) begin
                io.wb_tag  <= head.tag;
                io.wb_data <= head_res;
            end
            inflight <= inflight + 6'(accept) - 6'(head.valid);
        end
    end

`ifdef DIV_ALIGN_CHECK_EN
    // After reset the core may still deliver results for dropped ops, so the
    // check is blanked for one full tracker depth of non-stall cycles.
    logic [5:0] blank_cnt;
    logic       expect_out;

    assign expect_out = (head.valid | head.ghost) & ~head.byp;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err       <= 1'b0;
            blank_cnt <= 6'(LATENCY + 1);
        end else if (!stall) begin
            if (blank_cnt != 6'd0)              blank_cnt <= blank_cnt - 6'd1;
            else if (div_out_valid != expect_out) err       <= 1'b1;
        end
    end
`else
    logic unused_core_vld;
    assign unused_core_vld = div_out_valid;
    assign err             = 1'b0;
`endif

endmodule

// File: tb/tb_div_issue_ctrl.sv
module tb_div_issue_ctrl;
    localparam int L = 28;
`ifdef DIV_ALIGN_CHECK_EN
    localparam bit CHK_EN = 1'b1;
`else
    localparam bit CHK_EN = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n = 1'b0, stall = 1'b0, flush = 1'b0, inject = 1'b0;
    logic        div_valid, div_stall, div_out_valid;
    logic [31:0] div_dividend, div_divisor, div_quotient, div_remainder;
    logic [1:0]  div_ctrl;
    logic [5:0]  inflight;
    logic        err;

    div_issue_ctrl_if #(.TAG_W(5)) bus ();

    div_issue_ctrl #(.LATENCY(L), .TAG_W(5)) dut (
        .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush), .io(bus),
        .div_valid(div_valid), .div_dividend(div_dividend), .div_divisor(div_divisor),
        .div_ctrl(div_ctrl), .div_stall(div_stall), .div_quotient(div_quotient),
        .div_remainder(div_remainder), .div_out_valid(div_out_valid),
        .inflight(inflight), .err(err)
    );

    // ---------------- divider core model: fixed latency, not reset ----------------
    logic [L-1:0] cv = '0;
    logic [31:0]  cq [L];
    logic [31:0]  cr [L];
    always @(posedge clk) begin
        if (!div_stall) begin
            cv    <= {cv[L-2:0], div_valid};
            cq[0] <= (div_divisor != 0) ? div_dividend / div_divisor : 32'hFFFF_FFFF;
            cr[0] <= (div_divisor != 0) ? div_dividend % div_divisor : div_dividend;
            for (int i = 1; i < L; i++) begin
                cq[i] <= cq[i-1];
                cr[i] <= cr[i-1];
            end
        end
    end
    assign div_out_valid = cv[L-1] | inject;
    assign div_quotient  = cq[L-1];
    assign div_remainder = cr[L-1];

    // ---------------- bookkeeping ----------------
    int n_chk = 0, n_pass = 0, cyc = 0;

    function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s at cycle %0d: got %0h want %0h", nm, cyc, act, exp);
    endfunction

    // Architectural result, straight from the ISA rules.
    function automatic logic [31:0] ref_res(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        logic signed [31:0] sa, sb;
        logic ovf;
        sa  = a;
        sb  = b;
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        if (b == 0) return op[1] ? a : 32'hFFFF_FFFF;
        case (op)
            2'b00:   return ovf ? 32'h8000_0000 : 32'(sa / sb);
            2'b01:   return a / b;
            2'b10:   return ovf ? 32'd0 : 32'(sa % sb);
            default: return a % b;
        endcase
    endfunction

    function automatic logic [31:0] mag(input logic sgn, input logic [31:0] v);
        return (sgn && v[31]) ? 32'(-v) : v;
    endfunction

    // ---------------- reference model + per-cycle compare ----------------
    typedef struct { logic [4:0] tag; logic [31:0] data; int due; } pend_t;
    typedef struct { logic [4:0] tag; logic [31:0] data; int cyc; } wb_t;
    pend_t pend[$];
    wb_t   wb_log[$];
    int    ns = 0;
    logic        m_wbv = 0, m_dv = 0, m_err = 0;
    logic [4:0]  m_tag = 0;
    logic [31:0] m_dat = 0, m_dd = 0, m_ds = 0;
    logic [1:0]  m_ctrl = 0;
    int          m_inf = 0;
    logic        e_rs, e_st, e_fl, e_acc, e_byp;

    always @(posedge clk) begin
        e_rs  = rst_n;
        e_st  = stall;
        e_fl  = flush;
        e_acc = e_rs && !e_st && !e_fl && bus.req_valid;
        e_byp = (bus.req_b == 0) ||
                (!bus.req_op[0] && bus.req_a == 32'h8000_0000 && bus.req_b == 32'hFFFF_FFFF);
        if (!e_rs) begin
            pend.delete();
            m_wbv = 0; m_tag = 0; m_dat = 0; m_inf = 0; m_dv = 0; m_err = 0;
        end else begin
            if (CHK_EN && !e_st && inject) m_err = 1;
            if (e_fl) begin
                pend.delete();
                m_wbv = 0;
                m_inf = 0;
                if (!e_st) begin ns++; m_dv = 0; end
            end else if (!e_st) begin
                ns++;
                m_wbv = 0;
                if (pend.size() > 0 && pend[0].due == ns) begin
                    m_wbv = 1; m_tag = pend[0].tag; m_dat = pend[0].data;
                    void'(pend.pop_front());
                    m_inf--;
                end
                m_dv = e_acc && !e_byp;
                if (e_acc) begin
                    pend.push_back('{bus.req_tag, ref_res(bus.req_op, bus.req_a, bus.req_b), ns + L + 1});
                    m_inf++;
                    if (!e_byp) begin
                        m_dd   = mag(!bus.req_op[0], bus.req_a);
                        m_ds   = mag(!bus.req_op[0], bus.req_b);
                        m_ctrl = bus.req_op;
                    end
                end
            end
        end
        cyc++;
        #1;
        chk("wb_valid", bus.wb_valid, m_wbv);
        if (m_wbv) begin
            chk("wb_tag", bus.wb_tag, m_tag);
            chk("wb_data", bus.wb_data, m_dat);
        end
        chk("inflight", inflight, m_inf);
        chk("div_valid", div_valid, m_dv);
        if (m_dv) begin
            chk("div_dividend", div_dividend, m_dd);
            chk("div_divisor", div_divisor, m_ds);
            chk("div_ctrl", div_ctrl, m_ctrl);
        end
        chk("err", err, m_err);
        chk("req_ready", bus.req_ready, rst_n & ~stall);
        chk("div_stall", div_stall, stall);
        if (bus.wb_valid && !e_st && e_rs) wb_log.push_back('{bus.wb_tag, bus.wb_data, cyc});
    end

    // ---------------- stimulus helpers ----------------
    task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b, input logic [4:0] tag);
        bus.req_valid = 1; bus.req_op = op; bus.req_a = a; bus.req_b = b; bus.req_tag = tag;
        @(negedge clk);
        bus.req_valid = 0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_log(input int n, input int budget, input string nm);
        int k = 0;
        while (wb_log.size() < n && k < budget) begin @(negedge clk); k++; end
        chk(nm, 64'(wb_log.size() >= n), 64'd1);
    endtask

    function automatic wb_t logi(input int i);
        wb_t z = '{5'd0, 32'd0, -1};
        return (wb_log.size() > i) ? wb_log[i] : z;
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0:       return 32'd0;
            1:       return 32'h8000_0000;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'($urandom_range(0, 20));
            4:       return 32'(-$urandom_range(1, 20));
            default: return $urandom;
        endcase
    endfunction

    int c0, v0;
    // corner/interleave table: op, a, b, expected
    logic [1:0]  t_op  [6] = '{2'b01, 2'b00, 2'b10, 2'b00, 2'b10, 2'b10};
    logic [31:0] t_a   [6] = '{32'd5, 32'd100, 32'd5, 32'h8000_0000, 32'h8000_0000, 32'd100};
    logic [31:0] t_b   [6] = '{32'd0, 32'd7, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd7};
    logic [31:0] t_exp [6] = '{32'hFFFF_FFFF, 32'd14, 32'd5, 32'h8000_0000, 32'd0, 32'd2};

    initial begin
        bus.req_valid = 0; bus.req_op = 0; bus.req_a = 0; bus.req_b = 0; bus.req_tag = 0;
        idle(3);
        chk("reset req_ready", bus.req_ready, 0);
        chk("reset wb_valid", bus.wb_valid, 0);
        chk("reset inflight", inflight, 0);
        chk("reset err", err, 0);
        rst_n = 1;
        idle(2);

        // basic DIV 7/2 tag 3
        wb_log.delete();
        c0 = cyc;
        issue(2'b00, 32'd7, 32'd2, 5'd3);
        wait_log(1, 100, "basic timeout");
        chk("basic latency", logi(0).cyc - c0, 30);
        chk("basic tag", logi(0).tag, 3);
        chk("basic data", logi(0).data, 32'd3);

        // signed results back to back
        wb_log.delete();
        issue(2'b00, 32'hFFFF_FFF9, 32'd2, 5'd1);
        issue(2'b10, 32'hFFFF_FFF9, 32'd2, 5'd2);
        issue(2'b11, 32'hFFFF_FFF9, 32'd2, 5'd4);
        wait_log(3, 100, "signed timeout");
        chk("DIV -7/2", logi(0).data, 32'hFFFF_FFFD);
        chk("REM -7/2", logi(1).data, 32'hFFFF_FFFF);
        chk("REMU ..F9/2", logi(2).data, 32'h0000_0001);
        chk("signed consecutive 1", logi(1).cyc - logi(0).cyc, 1);
        chk("signed consecutive 2", logi(2).cyc - logi(1).cyc, 1);

        // corner cases interleaved with core-path ops
        wb_log.delete();
        for (int i = 0; i < 6; i++) issue(t_op[i], t_a[i], t_b[i], 5'(i + 16));
        wait_log(6, 100, "corner timeout");
        for (int i = 0; i < 6; i++) begin
            chk("corner data", logi(i).data, t_exp[i]);
            chk("corner tag", logi(i).tag, 64'(i + 16));
        end

        // stall held 10 cycles mid-flight
        wb_log.delete();
        c0 = cyc;
        issue(2'b00, 32'd7, 32'd2, 5'd9);
        idle(10);
        stall = 1;
        idle(1);
        v0 = inflight;
        idle(9);
        chk("stall inflight start", v0, 1);
        chk("stall inflight end", inflight, 1);
        stall = 0;
        wait_log(1, 100, "stall timeout");
        chk("stall latency", logi(0).cyc - c0, 40);
        chk("stall data", logi(0).data, 32'd3);

        // flush with 5 in flight
        wb_log.delete();
        for (int i = 0; i < 5; i++) issue(2'b00, 32'd50, 32'(i + 1), 5'(i + 10));
        idle(5);
        chk("pre-flush inflight", inflight, 5);
        flush = 1;
        idle(1);
        flush = 0;
        chk("post-flush inflight", inflight, 0);
        idle(L + 5);
        chk("flushed ops silent", wb_log.size(), 0);
        issue(2'b00, 32'd9, 32'd3, 5'd7);
        wait_log(1, 100, "post-flush timeout");
        chk("post-flush data", logi(0).data, 32'd3);
        chk("post-flush tag", logi(0).tag, 7);
        chk("post-flush err", err, 0);

        // reset mid-flight, then spurious core output
        wb_log.delete();
        for (int i = 0; i < 3; i++) issue(2'b01, 32'd90, 32'(i + 2), 5'(i + 20));
        wait_log(1, 100, "pre-reset timeout");
        chk("pre-reset wb_valid", bus.wb_valid, 1);
        rst_n = 0;
        idle(1);
        chk("rst wb_valid", bus.wb_valid, 0);
        chk("rst wb_tag", bus.wb_tag, 0);
        chk("rst wb_data", bus.wb_data, 0);
        chk("rst inflight", inflight, 0);
        chk("rst div_valid", div_valid, 0);
        chk("rst div operands", {div_dividend, div_divisor}, 0);
        chk("rst div_ctrl", div_ctrl, 0);
        chk("rst req_ready", bus.req_ready, 0);
        rst_n = 1;
        wb_log.delete();
        idle(L + 5);
        chk("dropped ops silent", wb_log.size(), 0);
        chk("err after reset", err, 0);
        inject = 1;
        idle(1);
        inject = 0;
        chk("err on spurious", err, CHK_EN);
        idle(5);
        chk("err sticky", err, CHK_EN);

        // randomized traffic against the model
        rst_n = 0;
        idle(1);
        rst_n = 1;
        for (int i = 0; i < 2000; i++) begin
            rst_n         = ($urandom_range(0, 299) != 0);
            stall         = ($urandom_range(0, 7) == 0);
            flush         = ($urandom_range(0, 49) == 0);
            bus.req_valid = $urandom_range(0, 1);
            bus.req_op    = 2'($urandom_range(0, 3));
            bus.req_a     = pick();
            bus.req_b     = pick();
            bus.req_tag   = 5'($urandom);
            idle(1);
        end
        rst_n = 1; stall = 0; flush = 0; bus.req_valid = 0;
        idle(L + 5);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
